// File: rtl/pixel_stream_sink_if.sv
// Avalon-ST pixel beat bundle between a pixel source and pixel_stream_sink.
interface pixel_stream_sink_if #(
  parameter int DATA_WIDTH = 30
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_startofpacket;
  logic                  s_endofpacket;
  logic                  s_empty;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_data, s_startofpacket, s_endofpacket, s_empty, s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data, s_startofpacket, s_endofpacket, s_empty, s_valid,
    output s_ready
  );
endinterface

// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: framing/length checks, per-frame checksum, good-frame count, irq.
// Optional random backpressure on s_ready when PIXEL_SINK_BACKPRESSURE_EN is defined.
module pixel_stream_sink #(
  parameter int DATA_WIDTH  = 30,
  parameter int CNT_W       = 22,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   pixel_clock,
  input  logic                   pixel_resetn,
  pixel_stream_sink_if.slave     sink,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       expected_pixels,
  input  logic [4:0]             err_mask,
  input  logic                   err_clear,
  input  logic                   irq_ack,
  output logic [DATA_WIDTH-1:0]  px_data,
  output logic                   px_valid,
  output logic                   px_sop,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [31:0]            last_checksum,
  output logic [4:0]             error_flags,
  output logic                   irq
);

  typedef enum logic [1:0] {S_IDLE, S_IN_FRAME, S_DROP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ready, w_ready_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_new, w_exp, r_exp, w_exp_nxt;
  logic [31:0]      r_ck, w_ck_nxt, w_ck_new, w_data_ext;
  logic [4:0]       w_err;
  logic             w_good, w_acc, w_sop, w_eop, w_track, r_done_pending;

  assign sink.s_ready = r_ready;
  assign w_acc        = sink.s_valid & r_ready;
  assign w_sop        = sink.s_startofpacket;
  assign w_eop        = sink.s_endofpacket;
  assign w_data_ext   = {{(32-DATA_WIDTH){1'b0}}, sink.s_data};

`ifdef PIXEL_SINK_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge pixel_clock or negedge pixel_resetn) begin
    if (!pixel_resetn) r_lfsr <= 16'hACE1;
    else               r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_ready_nxt = enable & (r_lfsr[0] | r_lfsr[1]);
`else
  assign w_ready_nxt = enable;
`endif

  assign w_cnt_new = w_sop ? CNT_W'(1) : ((r_cnt == '1) ? r_cnt : r_cnt + 1'b1);
  assign w_exp     = w_sop ? expected_pixels : r_exp;
  assign w_ck_new  = w_sop ? w_data_ext : ({r_ck[30:0], r_ck[31]} ^ w_data_ext);

  // An SOP beat is handled identically from IDLE, DROP and IN_FRAME (restart);
  // only the EARLY_SOP flag and the LONG check differ, so one tracking path serves all.
  assign w_track = w_sop | (r_state == S_IN_FRAME);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ck_nxt    = r_ck;
    w_exp_nxt   = r_exp;
    w_err       = '0;
    w_good      = 1'b0;
    if (w_acc) begin
      w_err[4] = sink.s_empty;
      if (w_track) begin
        w_cnt_nxt   = w_cnt_new;
        w_ck_nxt    = w_ck_new;
        w_exp_nxt   = w_exp;
        w_err[1]    = w_sop & (r_state == S_IN_FRAME);
        w_state_nxt = S_IN_FRAME;
        if (w_eop) begin
          if ((w_exp == '0) || (w_cnt_new == w_exp)) w_good   = 1'b1;
          else                                       w_err[2] = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!w_sop && (w_exp != '0) && (w_cnt_new == w_exp)) begin
          w_err[3]    = 1'b1;
          w_state_nxt = S_DROP;
        end
      end else if (r_state == S_IDLE) begin
        w_err[0] = 1'b1;
      end else if (w_eop) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge pixel_clock or negedge pixel_resetn) begin
    if (!pixel_resetn) begin
      r_state        <= S_IDLE;
      r_ready        <= 1'b0;
      r_cnt          <= '0;
      r_exp          <= '0;
      r_ck           <= '0;
      r_done_pending <= 1'b0;
      px_data        <= '0;
      px_valid       <= 1'b0;
      px_sop         <= 1'b0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
      last_checksum  <= '0;
      error_flags    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready    <= w_ready_nxt;
      r_cnt      <= w_cnt_nxt;
      r_exp      <= w_exp_nxt;
      r_ck       <= w_ck_nxt;
      px_valid   <= w_acc;
      frame_done <= w_good;
      if (w_acc) begin
        px_data <= sink.s_data;
        px_sop  <= w_sop;
      end
      if (w_good) begin
        frame_count   <= frame_count + 1'b1;
        last_checksum <= w_ck_new;
      end
      r_done_pending <= w_good | (r_done_pending & ~irq_ack);
      error_flags    <= (err_clear ? 5'b0 : error_flags) | w_err;
    end
  end

  assign irq = r_done_pending | (|(error_flags & err_mask));

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Directed bench for pixel_stream_sink with a forwarded-pixel scoreboard.
module tb_pixel_stream_sink;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, err_clear, irq_ack;
  logic [21:0] expected_pixels;
  logic [4:0]  err_mask;
  logic [29:0] px_data;
  logic        px_valid, px_sop, frame_done, irq;
  logic [15:0] frame_count;
  logic [31:0] last_checksum;
  logic [4:0]  error_flags;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [30:0] q[$];
  logic        mdl_ready;
  logic [31:0] ck;
  int unsigned fc;

  pixel_stream_sink_if #(.DATA_WIDTH(30)) sif ();

  pixel_stream_sink #(.DATA_WIDTH(30), .CNT_W(22), .FRAME_CNT_W(16)) dut (
    .pixel_clock(clk), .pixel_resetn(rst_n), .sink(sif),
    .enable(enable), .expected_pixels(expected_pixels), .err_mask(err_mask),
    .err_clear(err_clear), .irq_ack(irq_ack),
    .px_data(px_data), .px_valid(px_valid), .px_sop(px_sop),
    .frame_done(frame_done), .frame_count(frame_count),
    .last_checksum(last_checksum), .error_flags(error_flags), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef PIXEL_SINK_BACKPRESSURE_EN
  logic [15:0] mdl_lfsr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mdl_lfsr <= 16'hACE1;
    else        mdl_lfsr <= {mdl_lfsr[14:0], mdl_lfsr[15] ^ mdl_lfsr[13] ^ mdl_lfsr[12] ^ mdl_lfsr[10]};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mdl_ready <= 1'b0;
    else        mdl_ready <= enable & (mdl_lfsr[0] | mdl_lfsr[1]);
`else
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mdl_ready <= 1'b0;
    else        mdl_ready <= enable;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ck_step(input logic [31:0] c, input logic [29:0] d, input logic sop);
    logic [31:0] de;
    de = {2'b00, d};
    return sop ? de : ({c[30:0], c[31]} ^ de);
  endfunction

  // Forwarded pixel must appear exactly one cycle after each accepted beat.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("px_valid", px_valid, q.size() != 0);
      if (px_valid && q.size() != 0) begin
        logic [30:0] e;
        e = q.pop_front();
        chk("px_sop", px_sop, e[30]);
        chk("px_data", px_data, e[29:0]);
      end
    end
  end

  task automatic beat(input logic [29:0] d, input logic sop, input logic eop,
                      input logic emp = 1'b0, input bit tgl = 1'b0,
                      input logic clr = 1'b0, input logic ack = 1'b0);
    bit acc = 1'b0;
    int unsigned tries = 0;
    while (!acc && tries < 64) begin
      @(negedge clk);
      if (tgl) enable = 1'($urandom_range(0, 1));
      sif.s_data = d; sif.s_startofpacket = sop; sif.s_endofpacket = eop;
      sif.s_empty = emp; sif.s_valid = 1'b1;
      err_clear = clr; irq_ack = ack;
      chk("s_ready", sif.s_ready, mdl_ready);
      acc = mdl_ready;
      @(posedge clk);
      if (acc) q.push_back({sop, d});
      #1;
      sif.s_valid = 1'b0; err_clear = 1'b0; irq_ack = 1'b0;
      tries++;
    end
    chk("accept_bound", acc, 1'b1);
  endtask

  task automatic pulse(input logic clr, input logic ack);
    @(negedge clk);
    err_clear = clr; irq_ack = ack;
    @(posedge clk);
    #1;
    err_clear = 1'b0; irq_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_s_ready", sif.s_ready, 1'b0);
    chk("rst_px_valid", px_valid, 1'b0);
    chk("rst_px_data", px_data, 30'd0);
    chk("rst_px_sop", px_sop, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_checksum", last_checksum, 32'd0);
    chk("rst_error_flags", error_flags, 5'd0);
    chk("rst_irq", irq, 1'b0);
  endtask

  task automatic frame_checks(input string tag, input bit good, input logic [31:0] exp_ck,
                              input logic [4:0] exp_flags);
    @(negedge clk);
    if (good) fc++;
    chk({tag, "_done"}, frame_done, good);
    chk({tag, "_count"}, frame_count, fc[15:0]);
    if (good) chk({tag, "_checksum"}, last_checksum, exp_ck);
    chk({tag, "_flags"}, error_flags, exp_flags);
    @(negedge clk);
    chk({tag, "_done_pulse"}, frame_done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; err_clear = 1'b0; irq_ack = 1'b0;
    expected_pixels = '0; err_mask = '0; fc = 0;
    sif.s_data = '0; sif.s_startofpacket = 1'b0; sif.s_endofpacket = 1'b0;
    sif.s_empty = 1'b0; sif.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state();
    rst_n = 1'b1; enable = 1'b1;

    // NO_SOP on a stray beat after reset
    beat(30'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk("no_sop_flags", error_flags, 5'b00001);
    chk("no_sop_irq_masked", irq, 1'b0);
    pulse(1'b1, 1'b0);
    chk("no_sop_clear", error_flags, 5'b00000);

    // Good 4-beat frame: checksum 1,2,3,4 -> 2
    expected_pixels = 22'd4;
    beat(30'd1, 1'b1, 1'b0); beat(30'd2, 1'b0, 1'b0);
    beat(30'd3, 1'b0, 1'b0); beat(30'd4, 1'b0, 1'b1);
    frame_checks("good", 1'b1, 32'd2, 5'b00000);
    chk("good_irq", irq, 1'b1);
    pulse(1'b0, 1'b1);
    chk("good_irq_ack", irq, 1'b0);

    // Short frame
    beat(30'd5, 1'b1, 1'b0); beat(30'd6, 1'b0, 1'b0); beat(30'd7, 1'b0, 1'b1);
    frame_checks("short", 1'b0, 32'd0, 5'b00100);
    chk("short_irq_unmasked", irq, 1'b0);
    err_mask = 5'b00100;
    #1 chk("short_irq_masked", irq, 1'b1);
    pulse(1'b1, 1'b0);
    chk("short_clear", error_flags, 5'b00000);
    chk("short_clear_irq", irq, 1'b0);
    err_mask = 5'b00000;

    // Long frame: LONG at beat 2, rest dropped, then a good 2-beat frame
    expected_pixels = 22'd2;
    beat(30'd1, 1'b1, 1'b0); beat(30'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("long_flag", error_flags, 5'b01000);
    beat(30'd3, 1'b0, 1'b0); beat(30'd4, 1'b0, 1'b1);
    frame_checks("long_drop", 1'b0, 32'd0, 5'b01000);
    beat(30'd9, 1'b1, 1'b0); beat(30'd10, 1'b0, 1'b1);
    frame_checks("after_long", 1'b1, 32'd24, 5'b01000);
    pulse(1'b1, 1'b1);

    // Early SOP restarts the frame: restarted frame 3,4,5 -> checksum 1
    expected_pixels = 22'd3;
    beat(30'd1, 1'b1, 1'b0); beat(30'd2, 1'b0, 1'b0);
    beat(30'd3, 1'b1, 1'b0); beat(30'd4, 1'b0, 1'b0); beat(30'd5, 1'b0, 1'b1);
    frame_checks("early_sop", 1'b1, 32'd1, 5'b00010);
    pulse(1'b1, 1'b1);
    chk("early_ack_irq", irq, 1'b0);

    // EMPTY on a good single-beat frame, with clear and ack in the same cycle (set wins)
    expected_pixels = 22'd1;
    beat(30'h3FFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    frame_checks("empty", 1'b1, 32'h3FFFFFFF, 5'b10000);
    chk("empty_done_over_ack", irq, 1'b1);
    pulse(1'b1, 1'b1);
    chk("empty_cleared_irq", irq, 1'b0);

    // Handshake: enable toggles randomly, no length check
    expected_pixels = 22'd0;
    ck = '0;
    for (int i = 0; i < 8; i++) begin
      beat(30'(100 + i), i == 0, i == 7, 1'b0, 1'b1);
      ck = ck_step(ck, 30'(100 + i), i == 0);
    end
    enable = 1'b1;
    frame_checks("handshake", 1'b1, ck, 5'b00000);

    // Reset mid-frame, then a fresh good frame
    expected_pixels = 22'd4;
    beat(30'd11, 1'b1, 1'b0); beat(30'd12, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state();
    q.delete();
    fc = 0;
    rst_n = 1'b1;
    beat(30'd1, 1'b1, 1'b0); beat(30'd2, 1'b0, 1'b0);
    beat(30'd3, 1'b0, 1'b0); beat(30'd4, 1'b0, 1'b1);
    frame_checks("post_reset", 1'b1, 32'd2, 5'b00000);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
